divider_calibrator: RTL and testbench

Closed-loop trim controller for the fractional clock divider. It counts divider overflow pulses between reference pulses (e.g. synchronized GPS/RTC 1PPS) and compares the count to a target. It then computes a corrected increment and drives the divider's load/increment inputs, pulling the divider output onto the reference frequency. It sits between the reference-pulse synchronizer and the divider instance in the clock generation path.

---
 rtl/divider_calibrator_pkg.sv | 43 ++++
 rtl/calib_window_counter.sv | 46 ++++
 rtl/divider_calibrator.sv | 214 +++++++++++++++++++++
 tb/tb_divider_calibrator.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_calibrator_pkg.sv
// divider_calibrator_pkg
//   Shared definitions for the divider trim loop: FSM state encoding,
//   the fractional-divider increment width, default window parameters
//   (also used by the divider instance) and the increment saturation helper.
package divider_calibrator_pkg;

    // Increment width of the fractional divider.
    localparam int INCR_W = 25;

    // Default window parameters, shared with the divider instance.
    localparam int DEF_TARGET_COUNT = 32768;
    localparam int DEF_COUNT_W      = 20;

    // Correction step is sign-extended to STEP_W before the subtraction.
    // The subtraction itself uses SUM_W, which holds every possible result
    // without wrapping.
    localparam int STEP_W = 27;
    localparam int SUM_W  = STEP_W + 1;

    localparam logic [INCR_W-1:0] INCR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_MEASURE = 3'd2,
        ST_ADJUST  = 3'd3,
        ST_LOAD    = 3'd4
    } state_e;

    // Clamp a signed wide result onto the legal increment range [0, INCR_MAX].
    function automatic logic [INCR_W-1:0] sat_incr(input logic signed [SUM_W-1:0] v);
        logic [INCR_W-1:0] r;
        if (v < 0) begin
            r = '0;
        end else if (v > $signed({3'b000, INCR_MAX})) begin
            r = INCR_MAX;
        end else begin
            r = v[INCR_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/calib_window_counter.sv
// calib_window_counter
//   Saturating counter of divider overflow pulses within one reference window.
//   Ports:
//     i_clk, i_reset_n : clock, synchronous active-low reset
//     i_restart        : next count starts from 0 (window boundary / idle)
//     i_inc            : one-cycle overflow pulse
//     o_capture        : count including this cycle's i_inc, which is the
//                        value a window closing in this cycle must report
module calib_window_counter
    import divider_calibrator_pkg::*;
#(
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_restart,
    input  logic               i_inc,
    output logic [COUNT_W-1:0] o_capture
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] capture;

    always_comb begin
        // An overflow coinciding with the closing pulse belongs to the closing window.
        capture = count_q;
        if (i_inc && (count_q != COUNT_MAX)) begin
            capture = count_q + COUNT_W'(1);
        end
        count_d = i_restart ? '0 : capture;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_capture = capture;

endmodule

// File: rtl/divider_calibrator.sv
// divider_calibrator
//   Closed-loop trim controller for the fractional clock divider. Counts
//   divider overflows between reference pulses, compares against the target
//   and reloads a corrected increment into the divider.
//   Ports:
//     i_clk, i_reset_n  : clock, synchronous active-low reset
//     i_en              : level enable; low returns to IDLE, freezes increment
//     i_ref_pulse       : one-cycle synchronized reference pulse
//     i_div_overflow    : one-cycle divider overflow pulse
//     i_init_incriment  : increment loaded when leaving IDLE
//     o_load            : one-cycle load strobe, qualifies o_incriment
//     o_incriment       : increment presented to the divider
//     o_locked          : enough consecutive in-tolerance windows seen
//     o_ref_lost        : reference timed out; cleared by the next pulse
//     o_error           : signed error of the last completed window
//     o_dbg_state       : current FSM state
//   Strobe protocol: o_load is high for exactly one cycle and the divider
//   must take o_incriment in that cycle; there is no back-pressure.
module divider_calibrator
    import divider_calibrator_pkg::*;
#(
    parameter int TARGET_COUNT   = DEF_TARGET_COUNT,
    parameter int COUNT_W        = DEF_COUNT_W,
    parameter int GAIN_SHIFT     = 2,
    parameter int LOCK_TOL       = 1,
    parameter int LOCK_WINDOWS   = 4,
    parameter int TIMEOUT_CYCLES = 60_000_000
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_en,
    input  logic                      i_ref_pulse,
    input  logic                      i_div_overflow,
    input  logic [INCR_W-1:0]         i_init_incriment,
    output logic                      o_load,
    output logic [INCR_W-1:0]         o_incriment,
    output logic                      o_locked,
    output logic                      o_ref_lost,
    output logic signed [COUNT_W:0]   o_error,
    output state_e                    o_dbg_state
);

    localparam int ERR_W  = COUNT_W + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [TO_W-1:0]          TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GOOD_W-1:0]        GOOD_MAX = GOOD_W'(LOCK_WINDOWS);
    localparam logic signed [ERR_W-1:0]  TOL_S    = ERR_W'(LOCK_TOL);
    localparam logic signed [ERR_W-1:0]  TARGET_S = ERR_W'(TARGET_COUNT);

    state_e                    state_q, state_d;
    logic [INCR_W-1:0]         incr_q, incr_d;
    logic                      load_q, load_d;
    logic                      locked_q, locked_d;
    logic                      ref_lost_q, ref_lost_d;
    logic signed [ERR_W-1:0]   error_q, error_d;
    logic [COUNT_W-1:0]        count_cap_q, count_cap_d;
    logic [TO_W-1:0]           timeout_q, timeout_d;
    logic [GOOD_W-1:0]         good_q, good_d;

    logic                      win_restart;
    logic [COUNT_W-1:0]        win_capture;
    logic                      timed_out;
    logic                      err_in_tol;

    logic signed [ERR_W-1:0]   adj_error;
    logic signed [STEP_W-1:0]  adj_step;
    logic signed [SUM_W-1:0]   adj_sum;
    logic [INCR_W-1:0]         adj_new;

    calib_window_counter #(
        .COUNT_W (COUNT_W)
    ) u_window (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_restart (win_restart),
        .i_inc     (i_div_overflow),
        .o_capture (win_capture)
    );

    // Correction arithmetic, evaluated from the count captured at window close.
    always_comb begin
        adj_error = $signed({1'b0, count_cap_q}) - TARGET_S;
        adj_step  = {{(STEP_W - ERR_W){adj_error[ERR_W-1]}}, adj_error} <<< GAIN_SHIFT;
        adj_sum   = $signed({3'b000, incr_q}) - $signed({adj_step[STEP_W-1], adj_step});
        adj_new   = sat_incr(adj_sum);
    end

    assign err_in_tol = (error_q <= TOL_S) && (error_q >= -TOL_S);

    always_comb begin
        state_d     = state_q;
        incr_d      = incr_q;
        load_d      = 1'b0;
        locked_d    = locked_q;
        ref_lost_d  = ref_lost_q;
        error_d     = error_q;
        count_cap_d = count_cap_q;
        good_d      = good_q;
        timed_out   = 1'b0;

        // The window counter runs in every active state so a window that
        // starts during ADJUST/LOAD is never short; every pulse restarts it.
        win_restart = (state_q == ST_IDLE) || i_ref_pulse;

        if ((state_q == ST_IDLE) || i_ref_pulse) begin
            timeout_d = '0;
        end else if (timeout_q == TO_LAST) begin
            timeout_d = '0;
            timed_out = 1'b1;
        end else begin
            timeout_d = timeout_q + TO_W'(1);
        end

        if (i_ref_pulse) begin
            ref_lost_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    incr_d  = i_init_incriment;
                    load_d  = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (i_ref_pulse) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (i_ref_pulse) begin
                    count_cap_d = win_capture;
                    state_d     = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                // Result registered here so o_load/o_incriment/o_error are
                // all visible together two cycles after the closing pulse.
                error_d = adj_error;
                incr_d  = adj_new;
                load_d  = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (err_in_tol) begin
                    if (good_q != GOOD_MAX) begin
                        good_d = good_q + GOOD_W'(1);
                    end
                end else begin
                    good_d = '0;
                end
                locked_d = (good_d >= GOOD_MAX);
                state_d  = ST_MEASURE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Lost reference: abandon any in-flight update and re-arm.
        if (timed_out) begin
            ref_lost_d = 1'b1;
            locked_d   = 1'b0;
            good_d     = '0;
            incr_d     = incr_q;
            error_d    = error_q;
            load_d     = 1'b0;
            state_d    = ST_ARM;
        end

        if (!i_en) begin
            locked_d = 1'b0;
            good_d   = '0;
            incr_d   = incr_q;
            load_d   = 1'b0;
            state_d  = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            incr_q      <= '0;
            load_q      <= 1'b0;
            locked_q    <= 1'b0;
            ref_lost_q  <= 1'b0;
            error_q     <= '0;
            count_cap_q <= '0;
            timeout_q   <= '0;
            good_q      <= '0;
        end else begin
            state_q     <= state_d;
            incr_q      <= incr_d;
            load_q      <= load_d;
            locked_q    <= locked_d;
            ref_lost_q  <= ref_lost_d;
            error_q     <= error_d;
            count_cap_q <= count_cap_d;
            timeout_q   <= timeout_d;
            good_q      <= good_d;
        end
    end

    assign o_load      = load_q;
    assign o_incriment = incr_q;
    assign o_locked    = locked_q;
    assign o_ref_lost  = ref_lost_q;
    assign o_error     = error_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_divider_calibrator.sv
// tb_divider_calibrator
//   Directed test of divider_calibrator with a small loop configuration
//   (target 100, 8-bit window counter, gain shift 4, timeout 1000 cycles).
module tb_divider_calibrator;
    import divider_calibrator_pkg::*;

    localparam int     TGT      = 100;
    localparam int     CW       = 8;
    localparam int     GS       = 4;
    localparam int     TOL      = 1;
    localparam int     LW       = 4;
    localparam int     TO       = 1000;
    localparam longint CNT_MAX  = 255;
    localparam longint INC_MAXV = 33554431;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic ref_pulse = 1'b0;
    logic ovf = 1'b0;
    logic [24:0] init_incr = '0;

    logic               load;
    logic [24:0]        incr;
    logic               locked;
    logic               ref_lost;
    logic signed [CW:0] err;
    state_e             dbg_state;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider_calibrator #(
        .TARGET_COUNT   (TGT),
        .COUNT_W        (CW),
        .GAIN_SHIFT     (GS),
        .LOCK_TOL       (TOL),
        .LOCK_WINDOWS   (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (reset_n),
        .i_en             (en),
        .i_ref_pulse      (ref_pulse),
        .i_div_overflow   (ovf),
        .i_init_incriment (init_incr),
        .o_load           (load),
        .o_incriment      (incr),
        .o_locked         (locked),
        .o_ref_lost       (ref_lost),
        .o_error          (err),
        .o_dbg_state      (dbg_state)
    );

    // ---------------- behavioural model ----------------
    longint m_incr = 0;
    longint m_error = 0;
    int     m_good = 0;
    bit     m_locked = 1'b0;
    bit     m_ref_lost = 1'b0;
    bit     m_measuring = 1'b0;
    int     m_last_pulse = 0;

    typedef struct packed {
        logic [29:0] cyc;
        logic [8:0]  err;
        logic [24:0] incr;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_load(input int at_cyc, input longint e, input longint v);
        exp_t x;
        x.cyc  = 30'(at_cyc);
        x.err  = 9'(e);
        x.incr = 25'(v);
        exp_q.push_back(x);
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        while ((exp_q.size() > 0) && (int'(exp_q[0].cyc) < cyc)) begin
            total++;
            bad++;
            $display("FAIL load_missing: o_load low at cycle %0d, required high", int'(exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        if (load) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL load_unexpected: o_load=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_e = exp_q.pop_front();
                check("load_cycle", cyc, int'(exp_e.cyc));
                check("load_error", err, $signed(exp_e.err));
                check("load_incr", incr, exp_e.incr);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drop enable (checks IDLE and lock clear), then re-enable with a new init.
    task automatic restart(input longint init);
        en = 1'b0;
        tick();
        check("idle_after_en_low", dbg_state, ST_IDLE);
        check("locked_cleared_en_low", locked, 0);
        m_locked    = 1'b0;
        m_good      = 0;
        m_measuring = 1'b0;
        init_incr   = 25'(init);
        en          = 1'b1;
        m_incr      = init;
        push_load(cyc + 1, m_error, init);
        tick();
        tick();
    endtask

    // n overflows, a short quiet gap, then the reference pulse.
    task automatic window(input int n, input bit ovf_on_pulse);
        int     k;
        int     c;
        longint cnt;
        longint e;
        longint nv;
        k = ovf_on_pulse ? n - 1 : n;
        for (int i = 0; i < k; i++) begin
            ovf = 1'b1;
            tick();
        end
        ovf = 1'b0;
        repeat (3) tick();
        check("ref_lost_before_pulse", ref_lost, m_ref_lost);
        ref_pulse = 1'b1;
        ovf       = ovf_on_pulse;
        c         = cyc;
        tick();
        ref_pulse = 1'b0;
        ovf       = 1'b0;
        m_ref_lost   = 1'b0;
        m_last_pulse = c;
        check("ref_lost_after_pulse", ref_lost, 0);
        if (m_measuring) begin
            cnt = (n > CNT_MAX) ? CNT_MAX : longint'(n);
            e   = cnt - TGT;
            nv  = m_incr - e * (64'sd1 << GS);
            if (nv < 0) nv = 0;
            if (nv > INC_MAXV) nv = INC_MAXV;
            push_load(c + 2, e, nv);
            m_incr  = nv;
            m_error = e;
            if ((e <= TOL) && (e >= -TOL)) begin
                m_good = (m_good < LW) ? m_good + 1 : LW;
            end else begin
                m_good = 0;
            end
            m_locked = (m_good >= LW);
        end else begin
            m_measuring = 1'b1;
        end
        tick();
        tick();
        check("locked", locked, m_locked);
    endtask

    task automatic timeout_wait();
        while (cyc < m_last_pulse + TO) tick();
        check("ref_lost_before_timeout", ref_lost, 0);
        tick();
        check("ref_lost_at_timeout", ref_lost, 1);
        check("locked_at_timeout", locked, 0);
        check("state_at_timeout", dbg_state, ST_ARM);
        check("incr_kept_at_timeout", incr, m_incr);
        m_ref_lost  = 1'b1;
        m_locked    = 1'b0;
        m_good      = 0;
        m_measuring = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: still running at cycle %0d, required finish", cyc);
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        repeat (3) tick();
        check("rst_load", load, 0);
        check("rst_incr", incr, 0);
        check("rst_locked", locked, 0);
        check("rst_ref_lost", ref_lost, 0);
        check("rst_error", err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;
        tick();

        // +3 error: 1000 - 3*16 = 952
        restart(1000);
        window(0, 1'b0);
        window(103, 1'b0);
        check("lit_err_p3", err, 3);
        check("lit_incr_952", incr, 952);

        // -3 error, last overflow coincident with the closing pulse
        restart(1000);
        window(0, 1'b0);
        window(97, 1'b1);
        check("lit_err_m3", err, -3);
        check("lit_incr_1048", incr, 1048);

        // low saturation
        restart(10);
        window(0, 1'b0);
        window(200, 1'b0);
        check("lit_err_100", err, 100);
        check("lit_incr_sat_lo", incr, 0);

        // high saturation, then window counter saturation at 255
        restart(INC_MAXV - 5);
        window(0, 1'b0);
        window(0, 1'b0);
        check("lit_err_m100", err, -100);
        check("lit_incr_sat_hi", incr, INC_MAXV);
        window(300, 1'b0);
        check("lit_err_cnt_sat", err, 155);
        check("lit_incr_after_cnt_sat", incr, 33551951);

        // lock acquisition and loss
        restart(1000);
        window(0, 1'b0);
        window(100, 1'b0);
        window(101, 1'b0);
        window(99, 1'b0);
        check("lit_not_locked_3", locked, 0);
        window(100, 1'b0);
        check("lit_locked_4", locked, 1);
        window(105, 1'b0);
        check("lit_unlocked_105", locked, 0);

        // relock, then lose the reference
        window(100, 1'b0);
        window(100, 1'b0);
        window(100, 1'b0);
        window(101, 1'b0);
        check("lit_relocked", locked, 1);
        timeout_wait();
        window(0, 1'b0);
        check("state_after_rearm", dbg_state, ST_MEASURE);
        window(104, 1'b0);
        check("lit_err_after_rearm", err, 4);

        // relock, then enable drop clears lock
        window(100, 1'b0);
        window(100, 1'b0);
        window(100, 1'b0);
        window(100, 1'b0);
        check("lit_locked_before_en_drop", locked, 1);
        restart(1000);
        window(0, 1'b0);
        window(100, 1'b0);
        window(100, 1'b0);
        window(100, 1'b0);
        window(101, 1'b0);
        check("lit_locked_before_reset", locked, 1);

        // reset in the middle of a measurement window
        ovf = 1'b1;
        repeat (5) tick();
        check("state_before_reset", dbg_state, ST_MEASURE);
        reset_n = 1'b0;
        en      = 1'b0;
        tick();
        check("midrst_load", load, 0);
        check("midrst_incr", incr, 0);
        check("midrst_locked", locked, 0);
        check("midrst_ref_lost", ref_lost, 0);
        check("midrst_error", err, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        reset_n = 1'b1;
        ovf     = 1'b0;
        m_incr = 0; m_error = 0; m_good = 0;
        m_locked = 1'b0; m_ref_lost = 1'b0; m_measuring = 1'b0;
        tick();
        check("idle_held_after_reset", dbg_state, ST_IDLE);

        restart(1000);
        window(0, 1'b0);
        window(100, 1'b0);
        check("lit_err_zero", err, 0);
        check("lit_incr_unchanged", incr, 1000);

        repeat (3) tick();
        check("pending_loads", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
